// File: rtl/bram_dwc_buffered.sv
// Narrow-to-wide BRAM data width converter with a one-line read buffer.
// A narrow master word maps to one lane of a wide slave word. Writes go
// straight through to the slave (and patch the buffer on a tag match).
// Reads hit the buffered slave line or trigger a single-line fill.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | ready; accepts writes, read hits and read misses
// RD_WAIT | slave read in flight, down-counting the slave read latency
// RESP    | fill data presented to master this cycle; still accepts requests
module bram_dwc_buffered #(
    parameter int ADDR_BITW     = 32,
    parameter int MST_DATA_BITW = 32,
    parameter int SLV_DATA_BITW = 96,
    parameter int SLV_RD_LAT    = 1
) (
    input  logic                         Clk_CI,
    input  logic                         Rst_RI,
    input  logic                         FlushBuf_SI,
    input  logic                         MstEn_SI,
    input  logic [ADDR_BITW-1:0]         MstAddr_SI,
    input  logic [MST_DATA_BITW-1:0]     MstWr_DI,
    input  logic [MST_DATA_BITW/8-1:0]   MstWrEn_SI,
    output logic                         MstRdy_SO,
    output logic [MST_DATA_BITW-1:0]     MstRd_DO,
    output logic                         MstRdValid_SO,
    output logic                         SlvEn_SO,
    output logic [ADDR_BITW-1:0]         SlvAddr_SO,
    output logic [SLV_DATA_BITW-1:0]     SlvWr_DO,
    output logic [SLV_DATA_BITW/8-1:0]   SlvWrEn_SO,
    input  logic [SLV_DATA_BITW-1:0]     SlvRd_DI
);

    localparam int N         = SLV_DATA_BITW / MST_DATA_BITW;
    localparam int MST_BYTES = MST_DATA_BITW / 8;
    localparam int SLV_BYTES = SLV_DATA_BITW / 8;
    localparam int LANE_W    = (N > 1) ? $clog2(N) : 1;
    localparam int CNT_W     = 3;

    typedef enum logic [1:0] {IDLE, RD_WAIT, RESP} state_t;

    state_t                     state_q, state_d;
    logic [CNT_W-1:0]           cnt_q;

    logic [ADDR_BITW-1:0]       mw, sw, sw_addr;
    logic [LANE_W-1:0]          lane;
    logic                       accept, is_wr, hit;
    logic                       rd_hit, rd_miss, wr_acc, fill_done;

    logic                       buf_valid_q;
    logic [ADDR_BITW-1:0]       tag_q;
    logic [SLV_DATA_BITW-1:0]   buf_q;
    logic [ADDR_BITW-1:0]       pend_sw_q;
    logic [LANE_W-1:0]          pend_lane_q;
    logic                       flush_pend_q;

    logic [SLV_BYTES-1:0]       wr_be;
    logic [SLV_DATA_BITW-1:0]   wr_mask, wr_repl;

    // Only a read in flight blocks the master; RESP can accept the next request.
    assign MstRdy_SO = (state_q != RD_WAIT);

    // Address decode, hit detection and write lane steering.
    always_comb begin
        mw        = MstAddr_SI / ADDR_BITW'(MST_BYTES);
        sw        = mw / ADDR_BITW'(N);
        lane      = LANE_W'(mw % ADDR_BITW'(N));
        sw_addr   = sw * ADDR_BITW'(SLV_BYTES);
        accept    = MstEn_SI & MstRdy_SO;
        is_wr     = |MstWrEn_SI;
        // A flush arriving with a read must not let it use the stale line.
        hit       = buf_valid_q & (tag_q == sw) & ~FlushBuf_SI;
        rd_hit    = accept & ~is_wr & hit;
        rd_miss   = accept & ~is_wr & ~hit;
        wr_acc    = accept & is_wr;
        fill_done = (state_q == RD_WAIT) && (cnt_q == '0);
        wr_be     = SLV_BYTES'(MstWrEn_SI) << (int'(lane) * MST_BYTES);
        wr_repl   = {N{MstWr_DI}};
        wr_mask   = '0;
        for (int b = 0; b < SLV_BYTES; b++) begin
            wr_mask[b*8 +: 8] = {8{wr_be[b]}};
        end
    end

    // State register.
    always_ff @(posedge Clk_CI or posedge Rst_RI) begin
        if (Rst_RI) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, RESP: state_d = rd_miss ? RD_WAIT : IDLE;
            RD_WAIT:    if (fill_done) state_d = RESP;
            default:    state_d = IDLE;
        endcase
    end

    // Slave read latency down-counter, loaded when a miss is accepted.
    always_ff @(posedge Clk_CI or posedge Rst_RI) begin
        if (Rst_RI) begin
            cnt_q <= '0;
        end else if (rd_miss) begin
            cnt_q <= CNT_W'(SLV_RD_LAT);
        end else if (state_q == RD_WAIT && cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    // Read buffer line, tag, valid bit and pending-miss bookkeeping.
    always_ff @(posedge Clk_CI or posedge Rst_RI) begin
        if (Rst_RI) begin
            buf_valid_q  <= 1'b0;
            tag_q        <= '0;
            buf_q        <= '0;
            pend_sw_q    <= '0;
            pend_lane_q  <= '0;
            flush_pend_q <= 1'b0;
        end else begin
            if (rd_miss) begin
                pend_sw_q    <= sw;
                pend_lane_q  <= lane;
                flush_pend_q <= 1'b0;
            end else if (state_q == RD_WAIT && FlushBuf_SI) begin
                flush_pend_q <= 1'b1;
            end

            if (fill_done) begin
                buf_q       <= SlvRd_DI;
                tag_q       <= pend_sw_q;
                // A flush seen during the fill still answers the master but
                // must not leave the line marked usable.
                buf_valid_q <= ~(flush_pend_q | FlushBuf_SI);
            end else begin
                if (wr_acc && buf_valid_q && tag_q == sw) begin
                    buf_q <= (buf_q & ~wr_mask) | (wr_repl & wr_mask);
                end
                if (FlushBuf_SI) buf_valid_q <= 1'b0;
            end
        end
    end

    // Registered slave request and master response outputs.
    always_ff @(posedge Clk_CI or posedge Rst_RI) begin
        if (Rst_RI) begin
            SlvEn_SO      <= 1'b0;
            SlvAddr_SO    <= '0;
            SlvWr_DO      <= '0;
            SlvWrEn_SO    <= '0;
            MstRd_DO      <= '0;
            MstRdValid_SO <= 1'b0;
        end else begin
            SlvEn_SO      <= 1'b0;
            SlvWrEn_SO    <= '0;
            MstRdValid_SO <= 1'b0;
            if (wr_acc) begin
                SlvEn_SO   <= 1'b1;
                SlvAddr_SO <= sw_addr;
                SlvWrEn_SO <= wr_be;
                SlvWr_DO   <= wr_repl;
            end
            if (rd_miss) begin
                SlvEn_SO   <= 1'b1;
                SlvAddr_SO <= sw_addr;
            end
            if (rd_hit) begin
                MstRd_DO      <= buf_q[int'(lane)*MST_DATA_BITW +: MST_DATA_BITW];
                MstRdValid_SO <= 1'b1;
            end
            if (fill_done) begin
                MstRd_DO      <= SlvRd_DI[int'(pend_lane_q)*MST_DATA_BITW +: MST_DATA_BITW];
                MstRdValid_SO <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bram_dwc_buffered.sv
// Directed bench for bram_dwc_buffered (32-bit master, 96-bit slave,
// slave read latency 2) with a small byte-enabled slave memory model.
module tb_bram_dwc_buffered;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        mst_en;
    logic [31:0] mst_addr;
    logic [31:0] mst_wr;
    logic [3:0]  mst_wren;
    logic        mst_rdy;
    logic [31:0] mst_rd;
    logic        mst_rd_valid;
    logic        slv_en;
    logic [31:0] slv_addr;
    logic [95:0] slv_wr;
    logic [11:0] slv_wren;
    logic [95:0] slv_rd;

    int errors = 0;
    int checks = 0;

    bram_dwc_buffered #(
        .ADDR_BITW(32), .MST_DATA_BITW(32), .SLV_DATA_BITW(96), .SLV_RD_LAT(LAT)
    ) dut (
        .Clk_CI(clk), .Rst_RI(rst), .FlushBuf_SI(flush),
        .MstEn_SI(mst_en), .MstAddr_SI(mst_addr), .MstWr_DI(mst_wr),
        .MstWrEn_SI(mst_wren), .MstRdy_SO(mst_rdy), .MstRd_DO(mst_rd),
        .MstRdValid_SO(mst_rd_valid), .SlvEn_SO(slv_en), .SlvAddr_SO(slv_addr),
        .SlvWr_DO(slv_wr), .SlvWrEn_SO(slv_wren), .SlvRd_DI(slv_rd)
    );

    always #5 clk = ~clk;

    // Slave BRAM model: byte-enabled writes, reads returned LAT cycles later.
    logic [95:0] mem [16];
    logic [95:0] rd_pipe [LAT];
    assign slv_rd = rd_pipe[LAT-1];

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = '0;
        for (int i = 0; i < LAT; i++) rd_pipe[i] = '0;
    end

    always @(posedge clk) begin
        if (slv_en) begin
            if (|slv_wren) begin
                for (int b = 0; b < 12; b++)
                    if (slv_wren[b]) mem[(slv_addr / 12) % 16][b*8 +: 8] <= slv_wr[b*8 +: 8];
            end else begin
                rd_pipe[0] <= mem[(slv_addr / 12) % 16];
            end
        end
        for (int k = 1; k < LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        mst_en   = 1'b1;
        mst_addr = a;
        mst_wr   = d;
        mst_wren = be;
    endtask

    task automatic idle();
        mst_en   = 1'b0;
        mst_wren = '0;
    endtask

    initial begin
        int pulses;
        rst = 1'b1; flush = 1'b0; mst_en = 1'b0;
        mst_addr = '0; mst_wr = '0; mst_wren = '0;
        tick(); tick();
        chk("rst_rdy", mst_rdy, 1);
        chk("rst_slv_en", slv_en, 0);
        chk("rst_valid", mst_rd_valid, 0);
        chk("rst_rd", mst_rd, 0);
        chk("rst_slv_addr", slv_addr, 0);
        rst = 1'b0;
        tick();

        // 1: write at 0x14 -> sw 1, lane 2
        req(32'h14, 32'hAABBCCDD, 4'hF);
        tick(); idle();
        chk("t1_slv_en", slv_en, 1);
        chk("t1_slv_addr", slv_addr, 32'h0C);
        chk("t1_slv_wren", slv_wren, 12'hF00);
        chk("t1_slv_wr_hi", slv_wr[95:64], 32'hAABBCCDD);
        chk("t1_slv_wr_all", slv_wr, {3{32'hAABBCCDD}});
        chk("t1_rdy", mst_rdy, 1);
        chk("t1_no_valid", mst_rd_valid, 0);

        // Populate slave word 0 through the converter.
        req(32'h00, 32'h11111111, 4'hF); tick();
        req(32'h04, 32'h22222222, 4'hF); tick();
        chk("fill_wren_lane1", slv_wren, 12'h0F0);
        req(32'h08, 32'h33333333, 4'hF); tick();
        chk("fill_wren_lane2", slv_wren, 12'hF00);
        idle(); tick();
        chk("idle_slv_en", slv_en, 0);

        // 2: read miss at 0x00, then hits on 0x04 and 0x08
        req(32'h00, 32'h0, 4'h0);
        chk("t2_c0_rdy", mst_rdy, 1);
        tick(); idle();
        chk("t2_c1_slv_en", slv_en, 1);
        chk("t2_c1_wren", slv_wren, 12'h000);
        chk("t2_c1_addr", slv_addr, 32'h0);
        chk("t2_c1_rdy", mst_rdy, 0);
        tick();
        chk("t2_c2_rdy", mst_rdy, 0);
        chk("t2_c2_slv_en", slv_en, 0);
        tick();
        chk("t2_c3_rdy", mst_rdy, 0);
        chk("t2_c3_valid", mst_rd_valid, 0);
        tick();
        chk("t2_c4_rdy", mst_rdy, 1);
        chk("t2_c4_valid", mst_rd_valid, 1);
        chk("t2_c4_data", mst_rd, 32'h11111111);
        req(32'h04, 32'h0, 4'h0);
        tick();
        chk("t2_hit1_valid", mst_rd_valid, 1);
        chk("t2_hit1_data", mst_rd, 32'h22222222);
        chk("t2_hit1_no_slv", slv_en, 0);
        req(32'h08, 32'h0, 4'h0);
        tick(); idle();
        chk("t2_hit2_valid", mst_rd_valid, 1);
        chk("t2_hit2_data", mst_rd, 32'h33333333);
        chk("t2_hit2_no_slv", slv_en, 0);
        tick();
        chk("t2_single_pulse", mst_rd_valid, 0);

        // 3: partial write into the buffered line, then read-back hit
        req(32'h04, 32'h0000BEEF, 4'h3);
        tick();
        chk("t3_slv_en", slv_en, 1);
        chk("t3_wren", slv_wren, 12'h030);
        chk("t3_wr_valid", mst_rd_valid, 0);
        req(32'h04, 32'h0, 4'h0);
        tick(); idle();
        chk("t3_hit_valid", mst_rd_valid, 1);
        chk("t3_hit_data", mst_rd, 32'h2222BEEF);
        chk("t3_hit_no_slv", slv_en, 0);

        // 4: flush, then a read of the same line misses
        flush = 1'b1; tick(); flush = 1'b0;
        req(32'h08, 32'h0, 4'h0);
        tick(); idle();
        chk("t4_miss_slv_en", slv_en, 1);
        chk("t4_miss_rdy", mst_rdy, 0);
        tick(); tick(); tick();
        chk("t4_valid", mst_rd_valid, 1);
        chk("t4_data", mst_rd, 32'h33333333);
        // Flush coinciding with an accepted read forces a miss.
        flush = 1'b1;
        req(32'h04, 32'h0, 4'h0);
        tick(); idle(); flush = 1'b0;
        chk("t4b_miss_slv_en", slv_en, 1);
        chk("t4b_no_hit", mst_rd_valid, 0);
        tick(); tick(); tick();
        chk("t4b_valid", mst_rd_valid, 1);
        chk("t4b_data", mst_rd, 32'h2222BEEF);

        // 5: reset during RD_WAIT
        req(32'h0C, 32'h0, 4'h0);
        tick(); idle();
        chk("t5_rdwait_rdy", mst_rdy, 0);
        rst = 1'b1; #1;
        chk("t5_rst_rdy", mst_rdy, 1);
        chk("t5_rst_slv_en", slv_en, 0);
        chk("t5_rst_slv_addr", slv_addr, 0);
        chk("t5_rst_slv_wr", slv_wr, 0);
        chk("t5_rst_slv_wren", slv_wren, 0);
        chk("t5_rst_rd", mst_rd, 0);
        chk("t5_rst_valid", mst_rd_valid, 0);
        tick(); rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (mst_rd_valid === 1'b1) pulses++;
        end
        chk("t5_no_pulse", pulses, 0);
        req(32'h00, 32'h0, 4'h0);
        tick(); idle();
        chk("t5_post_miss", slv_en, 1);
        chk("t5_post_rdy", mst_rdy, 0);
        tick(); tick(); tick();
        chk("t5_post_valid", mst_rd_valid, 1);
        chk("t5_post_data", mst_rd, 32'h11111111);

        // 6: ten back-to-back writes
        for (int i = 0; i < 10; i++) begin
            req(32'(i * 4), 32'(i), 4'hF);
            tick();
            chk($sformatf("t6_slv_en_%0d", i), slv_en, 1);
            chk($sformatf("t6_rdy_%0d", i), mst_rdy, 1);
            chk($sformatf("t6_addr_%0d", i), slv_addr, 32'((i / 3) * 12));
            chk($sformatf("t6_wren_%0d", i), slv_wren, 12'(12'hF << (4 * (i % 3))));
        end
        idle(); tick();
        chk("t6_end_slv_en", slv_en, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
